// File: rtl/alu_mul_seq_if.sv
// Operand/result bundle between the execute stage and the iterative multiplier.
// master = execute stage driving operands, slave = alu_mul_seq.
interface alu_mul_seq_if #(
    parameter int unsigned WIDTH = 24
);
    logic             Start;
    logic             Sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic             Busy;
    logic             Done;
    logic             Stall;

    modport master (
        output Start, Sign, A, B,
        input  Result, ResultHi, Busy, Done, Stall
    );

    modport slave (
        input  Start, Sign, A, B,
        output Result, ResultHi, Busy, Done, Stall
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier producing a 2*WIDTH product; stalls the pipeline while busy.
// Optional MUL_EARLY_EXIT_EN ends the run once the remaining multiplier bits are all zero.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned CNT_W = 5
) (
    input logic         CLK,
    input logic         RST_N,
    alu_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_step;
    logic [2*WIDTH-1:0] acc_final;
    logic               last_iter;

    assign a_mag = (bus.Sign && bus.A[WIDTH-1]) ? (~bus.A + 1'b1) : bus.A;
    assign b_mag = (bus.Sign && bus.B[WIDTH-1]) ? (~bus.B + 1'b1) : bus.B;

    // Add into the upper half, keep the carry, and shift the whole accumulator right.
    always_comb begin
        sum         = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step    = {sum, acc_q[WIDTH-1:1]};
        mplier_step = mplier_q >> 1;
    end

`ifdef MUL_EARLY_EXIT_EN
    // Skipped iterations would only shift zeros in; apply them all at once.
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_step == '0);
    assign acc_final = acc_step >> (CNT_W'(WIDTH - 1) - cnt_q);
`else
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    assign acc_final = acc_step;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.Start) state_d = StRun;
            StRun:   if (last_iter) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.Busy     = (state_q != StIdle);
        bus.Done     = (state_q == StDone);
        bus.Stall    = (state_q != StIdle) || (bus.Start && (state_q == StIdle));
        bus.Result   = res_q[WIDTH-1:0];
        bus.ResultHi = res_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_d    = res_q;
        neg_d    = neg_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            StRun: begin
                acc_d    = acc_step;
                mplier_d = mplier_step;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    res_d = neg_q ? (~acc_final + 1'b1) : acc_final;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            neg_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            neg_q    <= neg_d;
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed self-checking bench for alu_mul_seq; honours MUL_EARLY_EXIT_EN for latency expectations.
module tb_alu_mul_seq;
    localparam int unsigned WIDTH = 24;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_mul_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected Start-edge-to-Done latency in cycles.
    function automatic int exp_lat(input logic s, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] m;
        int hi;
`ifdef MUL_EARLY_EXIT_EN
        m  = (s && b[WIDTH-1]) ? (~b + 1'b1) : b;
        hi = 0;
        for (int i = 0; i < int'(WIDTH); i++) if (m[i]) hi = i;
        return hi + 2;
`else
        m  = b;
        hi = int'(m[0]);
        return hi * 0 + int'(WIDTH) + 1;
`endif
    endfunction

    // Issue one multiply and watch it to completion (bounded).
    task automatic do_mul(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int busy_n, output logic stall0);
        @(negedge clk);
        bus.Sign  = s;
        bus.A     = a;
        bus.B     = b;
        bus.Start = 1'b1;
        #1 stall0 = bus.Stall;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        lat    = -1;
        busy_n = 0;
        for (int i = 0; i < 60 && lat < 0; i++) begin
            @(negedge clk);
            if (bus.Busy) busy_n++;
            if (bus.Done) lat = i + 1;
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.Sign  = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        #12;
        checks++;
        if ({bus.Result, bus.ResultHi, bus.Busy, bus.Done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%h busy=%b done=%b want=0", bus.Result,
                     bus.ResultHi, bus.Busy, bus.Done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b done=%b stall=%b want 0/0/0", bus.Busy,
                     bus.Done, bus.Stall);
        end
    endtask

    task automatic test_unsigned_basic;
        int lat, busy_n;
        logic st;
        do_mul(1'b0, 24'd3, 24'd5, lat, busy_n, st);
        checks++;
        if (lat !== exp_lat(1'b0, 24'd5)) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=%0d", lat, exp_lat(1'b0, 24'd5));
        end
        checks++;
        if (busy_n !== exp_lat(1'b0, 24'd5)) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_n, exp_lat(1'b0, 24'd5));
        end
        checks++;
        if (bus.Result !== 24'h00000F || bus.ResultHi !== 24'h0) begin
            failures++;
            $display("FAIL basic_product got=%h_%h want=000000_00000f", bus.ResultHi, bus.Result);
        end
        checks++;
        if (st !== 1'b1) begin
            failures++;
            $display("FAIL basic_stall_on_start got=%b want=1", st);
        end
        @(negedge clk);
        checks++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse got done=%b busy=%b want 0/0", bus.Done, bus.Busy);
        end
    endtask

    task automatic test_signed;
        int lat, busy_n;
        logic st;
        do_mul(1'b1, 24'hFFFFFE, 24'd3, lat, busy_n, st);
        checks++;
        if (bus.Result !== 24'hFFFFFA || bus.ResultHi !== 24'hFFFFFF || lat !== exp_lat(1'b1, 24'd3))
        begin
            failures++;
            $display("FAIL signed_neg2x3 got=%h_%h lat=%0d want=ffffff_fffffa lat=%0d",
                     bus.ResultHi, bus.Result, lat, exp_lat(1'b1, 24'd3));
        end
        do_mul(1'b1, 24'h800000, 24'h800000, lat, busy_n, st);
        checks++;
        if (bus.Result !== 24'h000000 || bus.ResultHi !== 24'h400000 ||
            lat !== exp_lat(1'b1, 24'h800000)) begin
            failures++;
            $display("FAIL signed_minxmin got=%h_%h lat=%0d want=400000_000000 lat=%0d",
                     bus.ResultHi, bus.Result, lat, exp_lat(1'b1, 24'h800000));
        end
    endtask

    task automatic test_unsigned_max;
        int lat, busy_n;
        logic st;
        do_mul(1'b0, 24'hFFFFFF, 24'hFFFFFF, lat, busy_n, st);
        checks++;
        if (bus.Result !== 24'h000001 || bus.ResultHi !== 24'hFFFFFE) begin
            failures++;
            $display("FAIL unsigned_max got=%h_%h want=fffffe_000001", bus.ResultHi, bus.Result);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.Result !== 24'h000001 || bus.ResultHi !== 24'hFFFFFE) begin
            failures++;
            $display("FAIL unsigned_max_hold got=%h_%h want=fffffe_000001", bus.ResultHi,
                     bus.Result);
        end
    endtask

    task automatic test_start_while_busy;
        int done_n;
        int stall_bad;
        @(negedge clk);
        bus.Sign  = 1'b0;
        bus.A     = 24'd7;
        bus.B     = 24'd9;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        done_n    = 0;
        stall_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done) done_n++;
            if (done_n == 0 && bus.Stall !== 1'b1) stall_bad++;
            if (bus.Done && bus.Stall !== 1'b1) stall_bad++;
            if (i == 3) begin
                bus.A     = 24'd2;
                bus.B     = 24'd2;
                bus.Start = 1'b1;
            end
            if (i == 4) bus.Start = 1'b0;
        end
        checks++;
        if (done_n !== 1) begin
            failures++;
            $display("FAIL busy_done_count got=%0d want=1", done_n);
        end
        checks++;
        if (bus.Result !== 24'd63 || bus.ResultHi !== 24'd0) begin
            failures++;
            $display("FAIL busy_product got=%h_%h want=000000_00003f", bus.ResultHi, bus.Result);
        end
        checks++;
        if (stall_bad !== 0) begin
            failures++;
            $display("FAIL busy_stall got=%0d low cycles want=0", stall_bad);
        end
    endtask

    task automatic test_reset_mid_op;
        int done_n, lat, busy_n;
        logic st;
        @(negedge clk);
        bus.Sign  = 1'b0;
        bus.A     = 24'd5;
        bus.B     = 24'h800000;
        bus.Start = 1'b1;
        @(posedge clk);
        #1 bus.Start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.Result, bus.ResultHi, bus.Busy, bus.Done, bus.Stall} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h_%h busy=%b done=%b stall=%b want all 0",
                     bus.ResultHi, bus.Result, bus.Busy, bus.Done, bus.Stall);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.Done || bus.Busy) done_n++;
        end
        checks++;
        if (done_n !== 0) begin
            failures++;
            $display("FAIL midreset_no_done got=%0d active cycles want=0", done_n);
        end
        do_mul(1'b0, 24'd4, 24'd4, lat, busy_n, st);
        checks++;
        if (bus.Result !== 24'd16 || bus.ResultHi !== 24'd0 || lat !== exp_lat(1'b0, 24'd4)) begin
            failures++;
            $display("FAIL midreset_restart got=%h_%h lat=%0d want=000000_000010 lat=%0d",
                     bus.ResultHi, bus.Result, lat, exp_lat(1'b0, 24'd4));
        end
    endtask

    task automatic test_zero_hold;
        int lat, busy_n, bad;
        logic st;
        do_mul(1'b0, 24'h123456, 24'd0, lat, busy_n, st);
        checks++;
        if (bus.Result !== 24'd0 || bus.ResultHi !== 24'd0 || lat !== exp_lat(1'b0, 24'd0)) begin
            failures++;
            $display("FAIL zero_product got=%h_%h lat=%0d want=000000_000000 lat=%0d",
                     bus.ResultHi, bus.Result, lat, exp_lat(1'b0, 24'd0));
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.Result !== 24'd0 || bus.ResultHi !== 24'd0) bad++;
            if (bus.Stall !== 1'b0 || bus.Done !== 1'b0 || bus.Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL zero_hold_idle got=%0d bad samples want=0", bad);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_unsigned_basic;
        test_signed;
        test_unsigned_max;
        test_start_while_busy;
        test_reset_mid_op;
        test_zero_hold;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative shift-add multiplier for the 24-bit CPU. It sits beside the bit-sliced ALU in the execute stage.
- It takes the same A/B operands the ALU slices receive and produces a full double-width product. The Result port drives the writeback mux; ResultHi feeds a HI register.
- It replaces the ALU's combinational per-bit multiply for full-width MUL. While it works, it holds the pipeline through Stall.

Parameters:
- WIDTH, 24, operand width in bits. Product is 2*WIDTH bits.
- CNT_W, 5, iteration-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  rising-edge clock, the single clock of the block.
- RST_N  input  1  asynchronous, active-low reset.
- Start  input  1  request a multiply. Sampled only in IDLE.
- Sign  input  1  1 = two's-complement operands, 0 = unsigned. Sampled with Start.
- A  input  WIDTH  multiplicand. Sampled with Start.
- B  input  WIDTH  multiplier. Sampled with Start.
- Result  output  WIDTH  low half of the product.
- ResultHi  output  WIDTH  high half of the product.
- Busy  output  1  high whenever state != IDLE.
- Done  output  1  one-cycle pulse; product is valid.
- Stall  output  1  Busy OR (Start AND state==IDLE). Combinational; freezes the PC and pipeline.

Behaviour:
- Reset (RST_N low, any time, asynchronous):
  - state = IDLE; counter = 0.
  - Result = 0, ResultHi = 0, Busy = 0, Done = 0.
  - All internal registers cleared. An operation in flight is discarded with no Done.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 at edge k: latch magnitudes |A| and |B| (if Sign=1, otherwise raw values).
  - Latch neg = Sign & (A[WIDTH-1] ^ B[WIDTH-1]).
  - Clear the 2*WIDTH accumulator; counter = 0; go to RUN.
  - Start=0: stay in IDLE. Result and ResultHi hold their last values.
- RUN, each cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand into the accumulator upper half.
  - Shift the accumulator and multiplier right by 1; counter++.
  - After WIDTH iterations (counter == WIDTH-1 this cycle), go to DONE.
- DONE, one cycle:
  - Done = 1.
  - Result/ResultHi = neg ? (two's-complement negation of the 2*WIDTH accumulator) : accumulator. Registered at entry to DONE.
  - Next state is IDLE.
- Latency: Start accepted at edge k gives Done high during cycle k+WIDTH+1. That is 25 cycles for WIDTH=24. Busy is high for cycles k+1 through k+WIDTH+1.
- Start while RUN or DONE: ignored, with no queueing. The new operands are not sampled.
- Arithmetic:
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1). It is representable unsigned, so there is no overflow special case.
  - The product is exact in 2*WIDTH bits; no saturation.
- Result/ResultHi change only on entry to DONE or on reset.
- Done never asserts in IDLE except through the DONE state.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, after each iteration, if the post-shift multiplier register is 0, go straight to DONE. A minimum of 1 iteration always runs.
  - The accumulator is pre-aligned so the result equals the full-run result: remaining shifts are applied in a single combinational realign on DONE entry.
  - Latency = (index of the highest set bit of |B|) + 2 cycles from the Start edge to Done. B=0 gives 2 cycles.
- Undefined: fixed WIDTH+1 latency as above. The zero-detect logic is not instantiated.

Test Plan:
- Unsigned basic: Sign=0, A=3, B=5, Start for 1 cycle. Expect Result=0x00000F, ResultHi=0, Done high exactly 25 cycles after the Start edge, Busy high for 25 cycles. With MUL_EARLY_EXIT_EN, Done arrives at 4 cycles.
- Signed mixed: Sign=1, A=0xFFFFFE (-2), B=3. Expect Result=0xFFFFFA, ResultHi=0xFFFFFF. Sign=1 with A=0x800000, B=0x800000: expect ResultHi=0x400000, Result=0x000000.
- Unsigned max: A=B=0xFFFFFF, Sign=0. Expect ResultHi=0xFFFFFE, Result=0x000001.
- Start while busy: Start at k with A=7, B=9; Start again at k+5 with A=2, B=2. Expect exactly one Done, Result=63. Second request not accepted; Stall stays high throughout.
- Reset mid-operation: drop RST_N at k+10 for 1 cycle. Expect all outputs immediately 0 and no Done pulse. A new Start then computes 4*4 = 16 correctly.
- Zero and hold: A=0x123456, B=0. Expect Result=0, ResultHi=0. Result holds across 10 idle cycles with Start=0; Stall=0 during idle.
